// File: rtl/tlb_arb_pkg.sv
// Shared types and widths for the TLB search-port arbiter.
package tlb_arb_pkg;

  localparam int unsigned TLBNUM_DEF = 16;
  localparam int unsigned IDXW_DEF   = 4;
  localparam int unsigned VPN2W      = 19;
  localparam int unsigned ASIDW      = 8;
  localparam int unsigned PFNW       = 20;
  localparam int unsigned CW         = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_IF   = 2'd0,
    OWN_MEM  = 2'd1,
    OWN_TLBP = 2'd2
  } owner_e;

endpackage

// File: rtl/tlb_arb_pick.sv
// Grant selection: tlbp has absolute priority, if/mem share by round robin.
// Ports: en (grant window open), *_req (already qualified requests),
//        rr (preferred of if/mem on a tie), *_gnt (one-hot or zero grants).
module tlb_arb_pick
  import tlb_arb_pkg::*;
(
  input  logic   en,
  input  logic   if_req,
  input  logic   mem_req,
  input  logic   tlbp_req,
  input  owner_e rr,
  output logic   if_gnt,
  output logic   mem_gnt,
  output logic   tlbp_gnt
);

  always_comb begin
    if_gnt   = 1'b0;
    mem_gnt  = 1'b0;
    tlbp_gnt = 1'b0;
    if (en) begin
      if (tlbp_req) begin
        tlbp_gnt = 1'b1;
      end else if (if_req && mem_req) begin
        if (rr == OWN_MEM) mem_gnt = 1'b1;
        else               if_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (mem_req) begin
        mem_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_search_arb.sv
// Arbitrates the TLB's single search port among if, mem and tlbp lookups
// and holds the registered search result for the winning requester.
// Ports: clk/resetn; per requester r in {if,mem,tlbp}: r_req, r_vpn2, r_odd,
//        r_asid, r_gnt (same-cycle accept), r_rsp_valid, r_rsp_ready;
//        shared rsp_* result; s_* key out / result in for the TLB search port;
//        tlbwi_pending blocks grants; flush cancels if/mem traffic.
module tlb_search_arb
  import tlb_arb_pkg::*;
#(
  parameter int unsigned TLBNUM = TLBNUM_DEF,
  parameter int unsigned IDXW   = IDXW_DEF
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             if_req,
  input  logic [VPN2W-1:0] if_vpn2,
  input  logic             if_odd,
  input  logic [ASIDW-1:0] if_asid,
  output logic             if_gnt,
  output logic             if_rsp_valid,
  input  logic             if_rsp_ready,

  input  logic             mem_req,
  input  logic [VPN2W-1:0] mem_vpn2,
  input  logic             mem_odd,
  input  logic [ASIDW-1:0] mem_asid,
  output logic             mem_gnt,
  output logic             mem_rsp_valid,
  input  logic             mem_rsp_ready,

  input  logic             tlbp_req,
  input  logic [VPN2W-1:0] tlbp_vpn2,
  input  logic             tlbp_odd,
  input  logic [ASIDW-1:0] tlbp_asid,
  output logic             tlbp_gnt,
  output logic             tlbp_rsp_valid,
  input  logic             tlbp_rsp_ready,

  output logic             rsp_found,
  output logic [IDXW-1:0]  rsp_index,
  output logic [PFNW-1:0]  rsp_pfn,
  output logic [CW-1:0]    rsp_c,
  output logic             rsp_d,
  output logic             rsp_v,

  output logic [VPN2W-1:0] s_vpn2,
  output logic             s_odd,
  output logic [ASIDW-1:0] s_asid,
  input  logic             s_found,
  input  logic [IDXW-1:0]  s_index,
  input  logic [PFNW-1:0]  s_pfn,
  input  logic [CW-1:0]    s_c,
  input  logic             s_d,
  input  logic             s_v,

  input  logic             tlbwi_pending,
  input  logic             flush
);

  state_e     state;
  owner_e     owner;
  owner_e     rr;
  logic [2:0] valid_q;   // one-hot {tlbp, mem, if} response valid

  logic [2:0] rdy_vec;
  logic       hs;
  logic       drop;
  logic       grant_en;
  logic       pick_if;
  logic       pick_mem;
  logic       pick_tlbp;
  logic       any_gnt;
  owner_e     gnt_owner;
  logic       idx_ok;

  assign rdy_vec = {tlbp_rsp_ready, mem_rsp_ready, if_rsp_ready};

  // Owner consumes its response this cycle; frees the port for back-to-back issue.
  assign hs = (state == ST_RESP) && (|(valid_q & rdy_vec));

  // A flush kills an outstanding if/mem response; a tlbp probe always completes.
  assign drop = (state == ST_RESP) && flush && (owner != OWN_TLBP);

  assign grant_en = resetn && !tlbwi_pending && ((state == ST_IDLE) || hs);

  tlb_arb_pick u_pick (
    .en       (grant_en),
    .if_req   (if_req && !flush),
    .mem_req  (mem_req && !flush),
    .tlbp_req (tlbp_req),
    .rr       (rr),
    .if_gnt   (pick_if),
    .mem_gnt  (pick_mem),
    .tlbp_gnt (pick_tlbp)
  );

  assign if_gnt   = pick_if;
  assign mem_gnt  = pick_mem;
  assign tlbp_gnt = pick_tlbp;
  assign any_gnt  = pick_if || pick_mem || pick_tlbp;

  always_comb begin
    gnt_owner = OWN_IF;
    if (pick_mem)  gnt_owner = OWN_MEM;
    if (pick_tlbp) gnt_owner = OWN_TLBP;
  end

  // Search key follows the winner; idle port sees an all-zero key.
  always_comb begin
    s_vpn2 = '0;
    s_odd  = 1'b0;
    s_asid = '0;
    if (pick_tlbp) begin
      s_vpn2 = tlbp_vpn2;
      s_odd  = tlbp_odd;
      s_asid = tlbp_asid;
    end else if (pick_mem) begin
      s_vpn2 = mem_vpn2;
      s_odd  = mem_odd;
      s_asid = mem_asid;
    end else if (pick_if) begin
      s_vpn2 = if_vpn2;
      s_odd  = if_odd;
      s_asid = if_asid;
    end
  end

  // Guards a non-power-of-two TLB from reporting a hit on a nonexistent entry.
  assign idx_ok = (32'(s_index) < TLBNUM);

  assign if_rsp_valid   = valid_q[0];
  assign mem_rsp_valid  = valid_q[1];
  assign tlbp_rsp_valid = valid_q[2];

  // State, ownership, fairness pointer and captured search result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      rr        <= OWN_IF;
      valid_q   <= '0;
      rsp_found <= 1'b0;
      rsp_index <= '0;
      rsp_pfn   <= '0;
      rsp_c     <= '0;
      rsp_d     <= 1'b0;
      rsp_v     <= 1'b0;
    end else if (any_gnt) begin
      state     <= ST_RESP;
      owner     <= gnt_owner;
      valid_q   <= {pick_tlbp, pick_mem, pick_if};
      rsp_found <= s_found && idx_ok;
      rsp_index <= s_index;
      rsp_pfn   <= s_pfn;
      rsp_c     <= s_c;
      rsp_d     <= s_d;
      rsp_v     <= s_v;
      if (pick_if)       rr <= OWN_MEM;
      else if (pick_mem) rr <= OWN_IF;
    end else if (hs || drop) begin
      state   <= ST_IDLE;
      valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_tlb_search_arb.sv
// Randomized and directed scoreboard bench for tlb_search_arb.
module tb_tlb_search_arb;
  import tlb_arb_pkg::*;

  localparam int unsigned NENT = 16;
  localparam int unsigned IW   = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic             if_req, mem_req, tlbp_req;
  logic [18:0]      if_vpn2, mem_vpn2, tlbp_vpn2;
  logic             if_odd, mem_odd, tlbp_odd;
  logic [7:0]       if_asid, mem_asid, tlbp_asid;
  logic             if_gnt, mem_gnt, tlbp_gnt;
  logic             if_rsp_valid, mem_rsp_valid, tlbp_rsp_valid;
  logic             if_rsp_ready, mem_rsp_ready, tlbp_rsp_ready;
  logic             rsp_found, rsp_d, rsp_v;
  logic [IW-1:0]    rsp_index;
  logic [19:0]      rsp_pfn;
  logic [2:0]       rsp_c;
  logic [18:0]      s_vpn2;
  logic             s_odd;
  logic [7:0]       s_asid;
  logic             s_found, s_d, s_v;
  logic [IW-1:0]    s_index;
  logic [19:0]      s_pfn;
  logic [2:0]       s_c;
  logic             tlbwi_pending, flush;

  tlb_search_arb #(.TLBNUM(NENT), .IDXW(IW)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_vpn2(if_vpn2), .if_odd(if_odd), .if_asid(if_asid),
    .if_gnt(if_gnt), .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .mem_req(mem_req), .mem_vpn2(mem_vpn2), .mem_odd(mem_odd), .mem_asid(mem_asid),
    .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .tlbp_req(tlbp_req), .tlbp_vpn2(tlbp_vpn2), .tlbp_odd(tlbp_odd), .tlbp_asid(tlbp_asid),
    .tlbp_gnt(tlbp_gnt), .tlbp_rsp_valid(tlbp_rsp_valid), .tlbp_rsp_ready(tlbp_rsp_ready),
    .rsp_found(rsp_found), .rsp_index(rsp_index), .rsp_pfn(rsp_pfn),
    .rsp_c(rsp_c), .rsp_d(rsp_d), .rsp_v(rsp_v),
    .s_vpn2(s_vpn2), .s_odd(s_odd), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn),
    .s_c(s_c), .s_d(s_d), .s_v(s_v),
    .tlbwi_pending(tlbwi_pending), .flush(flush)
  );

  // ---------------- TLB contents model ----------------
  typedef struct {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0, pfn1;
    logic [2:0]  c0, c1;
    logic        d0, d1, v0, v1;
  } tent_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } res_t;

  tent_t tlb [NENT];

  function automatic res_t lookup(logic [18:0] vpn2, logic odd, logic [7:0] asid);
    res_t r;
    r = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (tlb[i].vpn2 == vpn2 && (tlb[i].g || tlb[i].asid == asid)) begin
        r.found = 1'b1;
        r.index = 4'(i);
        r.pfn   = odd ? tlb[i].pfn1 : tlb[i].pfn0;
        r.c     = odd ? tlb[i].c1   : tlb[i].c0;
        r.d     = odd ? tlb[i].d1   : tlb[i].d0;
        r.v     = odd ? tlb[i].v1   : tlb[i].v0;
      end
    end
    return r;
  endfunction

  always_comb begin
    res_t t;
    t = lookup(s_vpn2, s_odd, s_asid);
    s_found = t.found;
    s_index = t.index;
    s_pfn   = t.pfn;
    s_c     = t.c;
    s_d     = t.d;
    s_v     = t.v;
  end

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    owner_e owner;
    res_t   res;
  } exp_t;

  exp_t   exp_q[$];
  logic   m_busy;
  owner_e m_owner;
  owner_e m_pref;
  bit     mon_en = 1'b0;

  function automatic logic rdy_of(owner_e o);
    case (o)
      OWN_IF:  return if_rsp_ready;
      OWN_MEM: return mem_rsp_ready;
      default: return tlbp_rsp_ready;
    endcase
  endfunction

  function automatic logic [2:0] onehot(owner_e o);
    case (o)
      OWN_IF:  return 3'b001;
      OWN_MEM: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [27:0] key_of(owner_e o);
    case (o)
      OWN_IF:  return {if_vpn2, if_odd, if_asid};
      OWN_MEM: return {mem_vpn2, mem_odd, mem_asid};
      default: return {tlbp_vpn2, tlbp_odd, tlbp_asid};
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_busy  = 1'b0;
    m_owner = OWN_IF;
    m_pref  = OWN_IF;
  endtask

  // Predict this cycle's grant, check it, and push the expected response.
  task automatic model_step();
    logic       hs, drop, can, gv;
    owner_e     g;
    logic [27:0] k;
    hs   = m_busy && rdy_of(m_owner);
    drop = m_busy && flush && (m_owner != OWN_TLBP);
    can  = !m_busy || hs;
    gv   = 1'b0;
    g    = OWN_IF;
    if (can && !tlbwi_pending) begin
      if (tlbp_req) begin
        gv = 1'b1; g = OWN_TLBP;
      end else if (!flush) begin
        if (if_req && mem_req) begin gv = 1'b1; g = m_pref; end
        else if (if_req)       begin gv = 1'b1; g = OWN_IF; end
        else if (mem_req)      begin gv = 1'b1; g = OWN_MEM; end
      end
    end
    chk("gnt", {tlbp_gnt, mem_gnt, if_gnt}, gv ? onehot(g) : 3'b000);
    k = gv ? key_of(g) : 28'd0;
    chk("s_key", {s_vpn2, s_odd, s_asid}, k);
    if (gv) begin
      exp_q.push_back('{owner: g, res: lookup(k[27:9], k[8], k[7:0])});
      m_busy  = 1'b1;
      m_owner = g;
      if (g == OWN_IF)       m_pref = OWN_MEM;
      else if (g == OWN_MEM) m_pref = OWN_IF;
    end else if (hs || drop) begin
      m_busy = 1'b0;
    end
  endtask

  // Response monitor: compares whatever the DUT presents with the queue head.
  always @(posedge clk) begin
    #2;
    if (mon_en && resetn) begin
      if (exp_q.size() == 0) begin
        chk("rsp_valid_idle", {tlbp_rsp_valid, mem_rsp_valid, if_rsp_valid}, 3'b000);
      end else begin
        chk("rsp_valid", {tlbp_rsp_valid, mem_rsp_valid, if_rsp_valid}, onehot(exp_q[0].owner));
        chk("rsp_data", {rsp_found, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v}, exp_q[0].res);
        if (rdy_of(exp_q[0].owner) || (flush && exp_q[0].owner != OWN_TLBP))
          void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [18:0] rand_vpn2();
    if (($urandom % 4) != 0) return tlb[$urandom_range(0, NENT - 1)].vpn2;
    return 19'($urandom);
  endfunction

  task automatic drive(input logic ri, input logic rm, input logic rt,
                       input logic [2:0] rdy, input logic fl, input logic tw,
                       input bit fix, input logic [18:0] fv);
    @(posedge clk);
    #1;
    if_req = ri; mem_req = rm; tlbp_req = rt;
    {tlbp_rsp_ready, mem_rsp_ready, if_rsp_ready} = rdy;
    flush = fl; tlbwi_pending = tw;
    if_vpn2   = fix ? fv : rand_vpn2();
    mem_vpn2  = fix ? fv : rand_vpn2();
    tlbp_vpn2 = fix ? fv : rand_vpn2();
    if_odd    = fix ? 1'b0 : 1'($urandom);
    mem_odd   = fix ? 1'b0 : 1'($urandom);
    tlbp_odd  = fix ? 1'b0 : 1'($urandom);
    if_asid   = fix ? 8'd0 : 8'($urandom_range(0, 3));
    mem_asid  = fix ? 8'd0 : 8'($urandom_range(0, 3));
    tlbp_asid = fix ? 8'd0 : 8'($urandom_range(0, 3));
    #2;
    model_step();
  endtask

  task automatic clear_inputs();
    if_req = 0; mem_req = 0; tlbp_req = 0;
    if_vpn2 = '0; mem_vpn2 = '0; tlbp_vpn2 = '0;
    if_odd = 0; mem_odd = 0; tlbp_odd = 0;
    if_asid = '0; mem_asid = '0; tlbp_asid = '0;
    if_rsp_ready = 0; mem_rsp_ready = 0; tlbp_rsp_ready = 0;
    flush = 0; tlbwi_pending = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    mon_en = 1'b0;
    clear_inputs();
    model_clear();
    if_req = 1; mem_req = 1; tlbp_req = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {tlbp_gnt, mem_gnt, if_gnt}, 3'b000);
    chk("rst_valid", {tlbp_rsp_valid, mem_rsp_valid, if_rsp_valid}, 3'b000);
    chk("rst_rsp", {rsp_found, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v}, 30'd0);
    if_req = 0; mem_req = 0; tlbp_req = 0;
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) begin
      tlb[i].vpn2 = 19'(32'h100 + (i % 12));
      tlb[i].asid = 8'($urandom_range(0, 3));
      tlb[i].g    = 1'($urandom);
      tlb[i].pfn0 = 20'($urandom);
      tlb[i].pfn1 = 20'($urandom);
      tlb[i].c0   = 3'($urandom);
      tlb[i].c1   = 3'($urandom);
      tlb[i].d0   = 1'($urandom);
      tlb[i].d1   = 1'($urandom);
      tlb[i].v0   = 1'($urandom);
      tlb[i].v1   = 1'($urandom);
    end
    tlb[5].vpn2 = 19'h00012;
    tlb[5].g    = 1'b1;

    resetn = 1'b0;
    clear_inputs();
    model_clear();
    do_reset();

    // Single IF hit at index 5.
    drive(1, 0, 0, 3'b000, 0, 0, 1, 19'h00012);
    chk("d33_gnt", if_gnt, 1'b1);
    drive(0, 0, 0, 3'b001, 0, 0, 0, 19'h0);
    chk("d33_valid", if_rsp_valid, 1'b1);
    chk("d33_found", rsp_found, 1'b1);
    chk("d33_index", rsp_index, 4'd5);

    // Continuous if+mem requests alternate one grant per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 3'b111, 0, 0, 0, 19'h0);
      chk("d34_alt", {mem_gnt, if_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // tlbp wins; round robin pointer untouched.
    do_reset();
    drive(1, 1, 1, 3'b111, 0, 0, 0, 19'h0);
    chk("d35_tlbp", tlbp_gnt, 1'b1);
    drive(1, 1, 0, 3'b111, 0, 0, 0, 19'h0);
    chk("d35_if", if_gnt, 1'b1);
    drive(0, 0, 0, 3'b111, 0, 0, 0, 19'h0);

    // Flush drops a stalled mem response.
    drive(0, 1, 0, 3'b000, 0, 0, 0, 19'h0);
    chk("d36_mgnt", mem_gnt, 1'b1);
    drive(1, 1, 0, 3'b000, 0, 0, 0, 19'h0);
    drive(1, 1, 0, 3'b000, 1, 0, 0, 19'h0);
    chk("d36_noflgnt", {mem_gnt, if_gnt}, 2'b00);
    chk("d36_vhold", mem_rsp_valid, 1'b1);
    drive(0, 1, 0, 3'b000, 0, 0, 0, 19'h0);
    chk("d36_vdrop", mem_rsp_valid, 1'b0);
    chk("d36_idle", mem_gnt, 1'b1);

    // TLBWI in flight blocks every grant.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 3'b111, 0, 1, 0, 19'h0);
      if (i > 0) chk("d37_block", {tlbp_gnt, mem_gnt, if_gnt}, 3'b000);
    end
    drive(1, 1, 1, 3'b111, 0, 0, 0, 19'h0);
    chk("d37_resume", tlbp_gnt, 1'b1);
    drive(0, 0, 0, 3'b111, 0, 0, 0, 19'h0);

    // Asynchronous reset in the middle of a response.
    drive(0, 1, 0, 3'b000, 0, 0, 0, 19'h0);
    drive(0, 0, 0, 3'b000, 0, 0, 0, 19'h0);
    chk("d38_pre", mem_rsp_valid, 1'b1);
    #2;
    resetn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("d38_async", {tlbp_rsp_valid, mem_rsp_valid, if_rsp_valid}, 3'b000);
    model_clear();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    drive(1, 1, 0, 3'b111, 0, 0, 0, 19'h0);
    chk("d38_rr", if_gnt, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
            {($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 7},
            ($urandom % 10) == 0, ($urandom % 12) == 0, 0, 19'h0);
    end

    // Drain.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 3'b111, 0, 0, 0, 19'h0);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlb_search_arb.md
TLB_SEARCH_ARB -- requirements
Module: tlb_search_arb

Interface
REQ-001 SHALL have parameter TLBNUM, default 16: number of TLB entries.
REQ-002 SHALL have parameter IDXW, default 4: index width, log2(TLBNUM).
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have resetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have, for each r in {if, mem, tlbp}, r_req, input, 1: lookup request.
REQ-006 SHALL have, for each r, r_vpn2, input, 19: virtual page number / 2.
REQ-007 SHALL have, for each r, r_odd, input, 1: VA bit 12, the odd-page select.
REQ-008 SHALL have, for each r, r_asid, input, 8: address space ID.
REQ-009 SHALL have, for each r, r_gnt, output, 1: request accepted this cycle.
REQ-010 SHALL have, for each r, r_rsp_valid, output, 1: response held for requester r.
REQ-011 SHALL have, for each r, r_rsp_ready, input, 1: requester r accepts the response.
REQ-012 SHALL have rsp_found/rsp_index/rsp_pfn/rsp_c/rsp_d/rsp_v, outputs, 1/IDXW/20/3/1/1: shared registered response.
REQ-013 SHALL have s_vpn2/s_odd/s_asid, outputs, 19/1/8: search key to the TLB's single search port.
REQ-014 SHALL have s_found/s_index/s_pfn/s_c/s_d/s_v, inputs, 1/IDXW/20/3/1/1: combinational TLB search result.
REQ-015 SHALL have tlbwi_pending, input, 1: a TLBWI is in flight; block all grants.
REQ-016 SHALL have flush, input, 1: WB exception or ERET; cancels if/mem traffic.

Function
REQ-017 SHALL implement a 2-state FSM, IDLE and RESP, plus an owner register (IF/MEM/TLBP) and a round-robin pointer rr (IF/MEM).
REQ-018 SHALL permit a grant only when state==IDLE, or when state==RESP and owner_rsp_valid & owner_rsp_ready (back-to-back issue).
REQ-019 SHALL apply priority tlbp > round-robin(if, mem); rr selects the preferred requester when both if_req and mem_req are high.
REQ-020 SHALL toggle rr to the other requester after each if or mem grant; a tlbp grant SHALL leave rr unchanged.
REQ-021 SHALL assert at most one r_gnt per cycle, combinationally in the same cycle as the accepted r_req.
REQ-022 SHALL drive s_* from the granted requester's key in the grant cycle; when there is no grant, s_* SHALL be 0.
REQ-023 SHALL capture s_found..s_v into the rsp_* registers at the grant edge, set owner, and enter RESP (latency: response visible the cycle after the grant).
REQ-024 SHALL in RESP assert only owner_rsp_valid, holding it and rsp_* stable until owner_rsp_ready; then go to IDLE unless a new grant occurs in that cycle.
REQ-025 SHALL suppress every grant while tlbwi_pending==1; a RESP already in progress SHALL complete unaffected.
REQ-026 SHALL suppress if/mem grants in any cycle flush==1; a tlbp grant in that cycle remains allowed.
REQ-027 SHALL, on flush==1 in RESP with owner IF or MEM, drop the response and go to IDLE next cycle with no further rsp_valid; flush SHALL be ignored when owner==TLBP.
REQ-028 SHALL hold rsp_* when no capture occurs; rsp_* are don't-care when no r_rsp_valid is high.

Reset
REQ-029 SHALL, while resetn==0, force state=IDLE, owner=IF, rr=IF, all r_gnt=0, all r_rsp_valid=0, and rsp_*=0.
REQ-030 SHALL, when reset is asserted mid-RESP, discard the pending response without a handshake.

Structure
REQ-031 SHALL take the state enum, owner enum, TLBNUM/IDXW defaults and the VPN2/ASID/PFN widths from shared package tlb_arb_pkg.
REQ-032 SHALL instantiate one combinational sub-module, tlb_arb_pick (priority plus round-robin select); the rest stays flat.

Verification
REQ-033 SHALL cover: if_req=1, vpn2=0x00012, TLB hit at index 5 -> if_gnt same cycle; next cycle if_rsp_valid=1, rsp_index=5, rsp_found=1.
REQ-034 SHALL cover: if_req and mem_req held high continuously from reset, ready always 1 -> grants alternate IF, MEM, IF, MEM, with one grant per cycle.
REQ-035 SHALL cover: tlbp_req, if_req and mem_req high together -> tlbp_gnt first; rr is unchanged, so the next grant goes to IF.
REQ-036 SHALL cover: mem owner in RESP, mem_rsp_ready=0 for 3 cycles with flush pulsed at cycle 2 -> mem_rsp_valid deasserts; state is IDLE; no mem grant in the flush cycle.
REQ-037 SHALL cover: tlbwi_pending=1 for 4 cycles with all requests high -> zero grants; the grant resumes in the first cycle after tlbwi_pending falls.
REQ-038 SHALL cover: resetn pulled low asynchronously mid-RESP -> all rsp_valid=0 immediately; after release, rr=IF.
